// File: rtl/sdram_bus_bridge.sv
// Host-side front end for sdram_controller: command FIFO, single-request issue FSM, credit-limited reads
// and a response FIFO. Define SDRAM_BRIDGE_STATS_EN to add accepted-request counters.
module sdram_bus_bridge #(
   parameter int AW        = 24,
   parameter int DW        = 16,
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hst_req_valid,
   output logic            hst_req_ready,
   input  logic            hst_req_write,
   input  logic [AW-1:0]   hst_req_addr,
   input  logic [DW-1:0]   hst_req_wdata,
   input  logic [DW/8-1:0] hst_req_be,
   output logic            hst_rsp_valid,
   input  logic            hst_rsp_ready,
   output logic [DW-1:0]   hst_rsp_rdata,
   output logic            bus_req_read,
   output logic            bus_req_write,
   output logic [AW-1:0]   bus_req_addr,
   output logic            bus_req_burst,
   output logic [2:0]      bus_req_burst_len,
   output logic [DW-1:0]   bus_req_wdata,
   output logic [DW/8-1:0] bus_req_byteenable,
   input  logic            bus_req_ready,
   input  logic            bus_rsp_valid,
`ifdef SDRAM_BRIDGE_STATS_EN
   output logic [31:0]     stat_rd_cnt,
   output logic [31:0]     stat_wr_cnt,
`endif
   input  logic [DW-1:0]   bus_rsp_rdata
);

   localparam int BW  = DW / 8;
   localparam int EW  = 1 + AW + DW + BW;
   localparam int CPW = $clog2(CMD_DEPTH);
   localparam int RPW = $clog2(RSP_DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          state, state_d;
   logic            ready_en;
   logic [EW-1:0]   cmd_mem [CMD_DEPTH];
   logic [CPW-1:0]  cmd_wr_ptr, cmd_rd_ptr;
   logic [CPW:0]    cmd_count;
   logic [DW-1:0]   rsp_mem [RSP_DEPTH];
   logic [RPW-1:0]  rsp_wr_ptr, rsp_rd_ptr;
   logic [RPW:0]    rsp_count;
   logic [RPW:0]    rd_outstanding;
   logic [RPW+1:0]  inflight;
   logic            head_write;
   logic [AW-1:0]   head_addr;
   logic [DW-1:0]   head_wdata;
   logic [BW-1:0]   head_be;
   logic            head_ok, load, clear;
   logic            cmd_push, rsp_push, rsp_pop, rd_acc;

   assign hst_req_ready = ready_en & (cmd_count != (CPW+1)'(CMD_DEPTH));
   assign cmd_push      = hst_req_valid & hst_req_ready;
   assign {head_write, head_addr, head_wdata, head_be} = cmd_mem[cmd_rd_ptr];

   // The read currently held on the bus already owns a response slot.
   assign inflight = (RPW+2)'(rd_outstanding) + (RPW+2)'(rsp_count) + (RPW+2)'(bus_req_read);
   assign head_ok  = (cmd_count != '0) & (head_write | (inflight < (RPW+2)'(RSP_DEPTH)));

   assign rd_acc   = bus_req_read & bus_req_ready;
   assign rsp_push = bus_rsp_valid & (rd_outstanding != '0);
   assign rsp_pop  = hst_rsp_valid & hst_rsp_ready;

   assign hst_rsp_valid     = (rsp_count != '0);
   assign hst_rsp_rdata     = hst_rsp_valid ? rsp_mem[rsp_rd_ptr] : '0;
   assign bus_req_burst     = 1'b0;
   assign bus_req_burst_len = 3'd0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ready_en <= 1'b0;
      end else begin
         state    <= state_d;
         ready_en <= 1'b1;
      end
   end

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (head_ok) state_d = ISSUE;
         ISSUE:   if (bus_req_ready && !head_ok) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load  = 1'b0;
      clear = 1'b0;
      case (state)
         IDLE:    load = head_ok;
         ISSUE: begin
            load  = bus_req_ready & head_ok;
            clear = bus_req_ready & ~head_ok;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req_read       <= 1'b0;
         bus_req_write      <= 1'b0;
         bus_req_addr       <= '0;
         bus_req_wdata      <= '0;
         bus_req_byteenable <= '0;
      end else if (load) begin
         bus_req_read       <= ~head_write;
         bus_req_write      <= head_write;
         bus_req_addr       <= head_addr;
         bus_req_wdata      <= head_wdata;
         bus_req_byteenable <= head_write ? head_be : '1;
      end else if (clear) begin
         bus_req_read  <= 1'b0;
         bus_req_write <= 1'b0;
      end
   end

   // NOTE: FIFO storage is not reset; the pointers and counts alone decide what is valid.
   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem[cmd_wr_ptr] <= {hst_req_write, hst_req_addr, hst_req_wdata, hst_req_be};
      if (rsp_push) rsp_mem[rsp_wr_ptr] <= bus_rsp_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
         cmd_count  <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
         if (load)     cmd_rd_ptr <= cmd_rd_ptr + CPW'(1);
         case ({cmd_push, load})
            2'b10:   cmd_count <= cmd_count + (CPW+1)'(1);
            2'b01:   cmd_count <= cmd_count - (CPW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_wr_ptr     <= '0;
         rsp_rd_ptr     <= '0;
         rsp_count      <= '0;
         rd_outstanding <= '0;
      end else begin
         if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RPW'(1);
         if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RPW'(1);
         case ({rsp_push, rsp_pop})
            2'b10:   rsp_count <= rsp_count + (RPW+1)'(1);
            2'b01:   rsp_count <= rsp_count - (RPW+1)'(1);
            default: ;
         endcase
         case ({rd_acc, rsp_push})
            2'b10:   rd_outstanding <= rd_outstanding + (RPW+1)'(1);
            2'b01:   rd_outstanding <= rd_outstanding - (RPW+1)'(1);
            default: ;
         endcase
      end
   end

`ifdef SDRAM_BRIDGE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_rd_cnt <= '0;
         stat_wr_cnt <= '0;
      end else begin
         if (rd_acc && stat_rd_cnt != 32'hFFFF_FFFF) stat_rd_cnt <= stat_rd_cnt + 32'd1;
         if (bus_req_write && bus_req_ready && stat_wr_cnt != 32'hFFFF_FFFF)
            stat_wr_cnt <= stat_wr_cnt + 32'd1;
      end
   end
`endif

endmodule
